// File: rtl/neuron_buffer_swap_controller.sv
// Ping-pong neuron buffer controller: streams one layer out of the read buffer, writes it back
// LAT non-stalled cycles later into the other buffer, then swaps buffer roles.
module neuron_buffer_swap_controller #(
  parameter int A   = 7,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] lastAddress,
  input  logic         poolIn,
  input  logic         stall,
  input  logic [A-1:0] ioAddress,
  input  logic         ioWrite,
  output logic         readBufferSelect,
  output logic         doPooling,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic         nRWrite,
  output logic         nWWrite,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, SWAP} state_t;

  state_t         state;
  logic [A-1:0]   rd_cnt;
  logic [A-1:0]   last_addr;
  logic [LAT-1:0] pipe_vld;
  logic [A-1:0]   pipe_addr [LAT];
  logic           upper_vld;
  logic           drain_done;

  // The pipeline is empty after this edge when only the last stage may hold data and it retires now.
  always_comb begin
    upper_vld = 1'b0;
    for (int i = 0; i < LAT - 1; i++) upper_vld = upper_vld | pipe_vld[i];
    drain_done = !upper_vld && (!pipe_vld[LAT-1] || !stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      readBufferSelect <= 1'b0;
      doPooling        <= 1'b0;
      pipe_vld         <= '0;
      rd_cnt           <= '0;
      last_addr        <= '0;
    end else begin
      if (!stall) begin
        for (int i = LAT - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
        pipe_vld[0] <= (state == READ);
      end
      case (state)
        IDLE: if (start) begin
          state     <= READ;
          rd_cnt    <= '0;
          last_addr <= lastAddress;
          doPooling <= poolIn;
        end
        READ: if (!stall) begin
          if (rd_cnt == last_addr) state <= DRAIN;
          else rd_cnt <= rd_cnt + A'(1);
        end
        DRAIN: if (drain_done) state <= SWAP;
        SWAP: begin
          state            <= IDLE;
          readBufferSelect <= ~readBufferSelect;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address stages carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = LAT - 1; i > 0; i--) pipe_addr[i] <= pipe_addr[i-1];
      pipe_addr[0] <= rd_cnt;
    end
  end

  assign readBuffAddress  = (state == IDLE) ? ioAddress : rd_cnt;
  assign nRWrite          = (state == IDLE) && ioWrite;
  assign writeBuffAddress = pipe_addr[LAT-1];
  assign nWWrite          = pipe_vld[LAT-1] && !stall;
  assign busy             = (state != IDLE);
  assign done             = (state == SWAP);

endmodule

// File: doc/neuron_buffer_swap_controller.md
NEURON_BUFFER_SWAP_CONTROLLER -- requirements
Module: neuron_buffer_swap_controller

Interface
REQ-001 Parameter: A, default 7, neuron buffer address width.
REQ-002 Parameter: LAT, default 3, ≥1; non-stalled cycles from a read address issue to its write-back.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to process one layer.
REQ-006 lastAddress  in  A  final word address of the layer; layer length is lastAddress+1.
REQ-007 poolIn  in  1  pooling mode for the layer, sampled with start.
REQ-008 stall  in  1  freezes the address counter and write-back pipeline while high.
REQ-009 ioAddress  in  A  host address into the read buffer, used only in IDLE.
REQ-010 ioWrite  in  1  host write strobe into the read buffer, used only in IDLE.
REQ-011 readBufferSelect  out  1  ping-pong select: 0 means N1 is read, 1 means N2 is read.
REQ-012 doPooling  out  1  latched poolIn for the active layer.
REQ-013 readBuffAddress  out  A  read buffer address.
REQ-014 writeBuffAddress  out  A  write buffer address.
REQ-015 nRWrite  out  1  read buffer write enable.
REQ-016 nWWrite  out  1  write buffer write enable.
REQ-017 busy  out  1  high in any non-IDLE state.
REQ-018 done  out  1  one-cycle layer-complete pulse.

Function
REQ-019 FSM states: IDLE, READ, DRAIN, SWAP.
- IDLE to READ: start=1.
- READ to DRAIN: a non-stalled cycle with readBuffAddress==lastAddress.
- DRAIN to SWAP: write-back pipeline is empty.
- SWAP to IDLE: unconditional, after one cycle.
REQ-020 The block accepts start only in IDLE; start in any other state is ignored with no side effect.
REQ-021 On start acceptance, the block latches doPooling from poolIn and lastAddress internally. Later changes to these inputs have no effect until the next accepted start.
REQ-022 In IDLE, readBuffAddress equals ioAddress and nRWrite equals ioWrite, combinationally.
REQ-023 Outside IDLE, nRWrite is 0.
REQ-024 In READ, readBuffAddress starts at 0 on the first READ cycle and increments by 1 per non-stalled cycle; it holds while stall=1.
REQ-025 Each non-stalled READ cycle issues the current readBuffAddress into an LAT-stage valid+address pipeline.
REQ-026 The pipeline advances only when stall=0. A bubble (valid=0) enters the pipeline in DRAIN and in non-stalled IDLE cycles.
REQ-027 writeBuffAddress equals the address in the last pipeline stage.
REQ-028 nWWrite = last-stage valid AND NOT stall. Every issued address is therefore written exactly once, LAT non-stalled cycles after it was issued.
REQ-029 The block writes addresses in order; none is skipped or duplicated.
REQ-030 done is 1 only during the SWAP cycle.
REQ-031 readBufferSelect toggles on the clock edge leaving SWAP and is constant at all other times. The new layer therefore reads what the previous layer wrote.
REQ-032 stall=1 in SWAP does not delay the swap.
REQ-033 lastAddress=0 processes exactly one word.
REQ-034 lastAddress=2^A-1 processes every address; the counter does not wrap within a layer.

Reset
REQ-035 When reset=1 at a clock edge, next-cycle values are:
- state IDLE
- readBufferSelect 0
- doPooling 0
- all pipeline valid bits 0
- internal read counter 0
- busy 0
- done 0
- nWWrite 0
REQ-036 Reset during READ or DRAIN aborts the layer. No further nWWrite pulses occur and no swap occurs.
REQ-037 Reset has priority over start in the same cycle.

Verification (A=7, LAT=3)
REQ-038 Basic layer: reset, then start with lastAddress=4, no stall.
- reads 0..4 in cycles 1..5
- nWWrite high in cycles 4..8 with writeBuffAddress 0..4
- done in cycle 9
- readBufferSelect becomes 1 at cycle 10
REQ-039 Stall: same layer with stall=1 in cycles 2..3.
- readBuffAddress holds at 1 during the stall
- each address 0..4 is written exactly once with nWWrite=0 during stall
- done is delayed by 2 cycles
REQ-040 Back-to-back layers: start issued again on the cycle after done, with poolIn=1.
- second layer reads with readBufferSelect=1 and doPooling=1
- readBufferSelect returns to 0 after the second done
REQ-041 IO and ignored start: in IDLE, drive ioWrite=1 with ioAddress=0x55.
- nRWrite=1 and readBuffAddress=0x55
- during READ, nRWrite stays 0 and a start pulse is ignored
REQ-042 Reset mid-layer: assert reset during the cycle-3 READ.
- nWWrite is never asserted afterward
- readBufferSelect=0, busy=0, no done pulse
REQ-043 Boundaries:
- lastAddress=0: exactly one write, to address 0
- lastAddress=127: exactly 128 writes, addresses 0..127 in order
